// File: rtl/register_bank_fwd_if.sv
// Decode-stage operand bus for register_bank_fwd: instruction word, stage results,
// forwarding selects and the registered A/B operands.
interface register_bank_fwd_if #(
  parameter int DW = 8,
  parameter int AW = 5,
  parameter int IW = 20
);
  logic [IW-1:0] ins;
  logic [AW-1:0] RW_dm;
  logic [DW-1:0] ans_ex;
  logic [DW-1:0] mux_ans_dm;
  logic [DW-1:0] ans_wb;
  logic [DW-1:0] imm;
  logic [1:0]    mux_sel_a;
  logic [1:0]    mux_sel_b;
  logic          imm_sel;
  logic [DW-1:0] A;
  logic [DW-1:0] B;

  // No handshake: the consumer samples A/B every cycle and the producer
  // presents new inputs every cycle; there is no valid, ready or stall.
  modport master (
    output ins, RW_dm, ans_ex, mux_ans_dm, ans_wb, imm, mux_sel_a, mux_sel_b, imm_sel,
    input  A, B
  );

  modport slave (
    input  ins, RW_dm, ans_ex, mux_ans_dm, ans_wb, imm, mux_sel_a, mux_sel_b, imm_sel,
    output A, B
  );
endinterface

// File: rtl/register_bank_fwd.sv
// Decode-stage register file (32 x 8, one write, two read ports) feeding the ID/EX
// latch through forwarding muxes; B can take the immediate instead.
module register_bank_fwd #(
  parameter int DW = 8,
  parameter int AW = 5,
  parameter int IW = 20
) (
  input logic             clk,
  input logic             reset,
  register_bank_fwd_if.slave bus
);
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] ra_val;
  logic [DW-1:0] rb_val;
  logic [DW-1:0] a_next;
  logic [DW-1:0] b_next;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;

  // Opcode and rd fields belong to other stages.
  logic unused_ins;
  assign unused_ins = ^bus.ins[IW-1:2*AW];

  assign ra = bus.ins[2*AW-1:AW];
  assign rb = bus.ins[AW-1:0];

  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] reg_val,
                                            input logic [DW-1:0] ex, input logic [DW-1:0] dm,
                                            input logic [DW-1:0] wb);
    case (sel)
      2'd0:    return reg_val;
      2'd1:    return ex;
      2'd2:    return dm;
      default: return wb;
    endcase
  endfunction

  // Write-through: a read of the address being written this cycle sees the new data.
  always_comb begin
    ra_val = (ra == bus.RW_dm) ? bus.mux_ans_dm : regs[ra];
    rb_val = (rb == bus.RW_dm) ? bus.mux_ans_dm : regs[rb];
    a_next = fwd_mux(bus.mux_sel_a, ra_val, bus.ans_ex, bus.mux_ans_dm, bus.ans_wb);
    b_next = bus.imm_sel ? bus.imm
                         : fwd_mux(bus.mux_sel_b, rb_val, bus.ans_ex, bus.mux_ans_dm, bus.ans_wb);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      regs[bus.RW_dm] <= bus.mux_ans_dm;
      a_q             <= a_next;
      b_q             <= b_next;
    end
  end

  assign bus.A = a_q;
  assign bus.B = b_q;
endmodule

// File: tb/tb_register_bank_fwd.sv
// Bench for register_bank_fwd: directed vector table, mid-cycle reset sequences and
// randomized traffic against a register-array reference model.
`timescale 1ns/1ps
module tb_register_bank_fwd;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int IW = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #500 clk = ~clk;

  register_bank_fwd_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();

  register_bank_fwd #(.DW(DW), .AW(AW), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] rw;
    logic [DW-1:0] dm;
    logic [1:0]    sa;
    logic [1:0]    sb;
    logic          isel;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  logic [DW-1:0] m_regs [2**AW];
  logic [DW-1:0] m_a, m_b;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [IW-1:0] ins, input logic [AW-1:0] rw, input logic [DW-1:0] dm,
                       input logic [DW-1:0] ex, input logic [DW-1:0] wb, input logic [DW-1:0] imm,
                       input logic [1:0] sa, input logic [1:0] sb, input logic isel);
    bus.ins = ins; bus.RW_dm = rw; bus.mux_ans_dm = dm; bus.ans_ex = ex; bus.ans_wb = wb;
    bus.imm = imm; bus.mux_sel_a = sa; bus.mux_sel_b = sb; bus.imm_sel = isel;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r,
                                         input logic [DW-1:0] ex, input logic [DW-1:0] dm,
                                         input logic [DW-1:0] wb);
    logic [DW-1:0] srcs [4];
    srcs[0] = r; srcs[1] = ex; srcs[2] = dm; srcs[3] = wb;
    return srcs[sel];
  endfunction

  // Model: apply this edge's write to the array first, then read it.
  task automatic model_edge();
    logic [DW-1:0] nxt [2**AW];
    nxt = m_regs;
    nxt[bus.RW_dm] = bus.mux_ans_dm;
    m_a = pick(bus.mux_sel_a, nxt[bus.ins[9:5]], bus.ans_ex, bus.mux_ans_dm, bus.ans_wb);
    m_b = bus.imm_sel ? bus.imm
                      : pick(bus.mux_sel_b, nxt[bus.ins[4:0]], bus.ans_ex, bus.mux_ans_dm, bus.ans_wb);
    m_regs = nxt;
  endtask

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_a = '0;
    m_b = '0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs.push_back('{rw: 5'd5, dm: 8'h02, sa: 2'd0, sb: 2'd0, isel: 1'b0, exp_a: 8'h00, exp_b: 8'h02});
    vecs.push_back('{rw: 5'd6, dm: 8'h05, sa: 2'd0, sb: 2'd0, isel: 1'b0, exp_a: 8'h05, exp_b: 8'h02});
    vecs.push_back('{rw: 5'd7, dm: 8'h05, sa: 2'd1, sb: 2'd0, isel: 1'b0, exp_a: 8'h01, exp_b: 8'h02});
    vecs.push_back('{rw: 5'd7, dm: 8'h05, sa: 2'd2, sb: 2'd3, isel: 1'b0, exp_a: 8'h05, exp_b: 8'h03});
    vecs.push_back('{rw: 5'd7, dm: 8'h05, sa: 2'd2, sb: 2'd3, isel: 1'b1, exp_a: 8'h05, exp_b: 8'h04});

    drive(20'h014C5, 5'd0, 8'h00, 8'h01, 8'h03, 8'h04, 2'd0, 2'd0, 1'b0);
    #200 reset = 1'b0;
    #10;
    check("reset_a_immediate", bus.A, 8'h00);
    check("reset_b_immediate", bus.B, 8'h00);
    #490;
    check("reset_a_window", bus.A, 8'h00);
    check("reset_b_window", bus.B, 8'h00);
    #100 reset = 1'b1;

    foreach (vecs[i]) begin
      drive(20'h014C5, vecs[i].rw, vecs[i].dm, 8'h01, 8'h03, 8'h04, vecs[i].sa, vecs[i].sb, vecs[i].isel);
      tick();
      check($sformatf("vec%0d_a", i), bus.A, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), bus.B, vecs[i].exp_b);
    end

    // Reset between edges clears A/B at once and wipes reg5.
    #200 reset = 1'b0;
    #10;
    check("midreset_a", bus.A, 8'h00);
    check("midreset_b", bus.B, 8'h00);
    #100 reset = 1'b1;
    drive(20'h014C5, 5'd0, 8'h09, 8'h01, 8'h03, 8'h04, 2'd0, 2'd0, 1'b0);
    tick();
    check("post_reset_reg6", bus.A, 8'h00);
    check("post_reset_reg5", bus.B, 8'h00);

    // Address 0 holds data; RA == RB both see it, and a later write-through wins.
    drive({10'h0, 5'd0, 5'd0}, 5'd1, 8'h11, 8'h01, 8'h03, 8'h04, 2'd0, 2'd0, 1'b0);
    tick();
    check("reg0_written_a", bus.A, 8'h09);
    check("reg0_written_b", bus.B, 8'h09);
    drive({10'h0, 5'd0, 5'd0}, 5'd0, 8'h77, 8'h01, 8'h03, 8'h04, 2'd0, 2'd0, 1'b0);
    tick();
    check("same_addr_bypass_a", bus.A, 8'h77);
    check("same_addr_bypass_b", bus.B, 8'h77);

    // Randomized traffic against the model, starting from a fresh reset.
    #200 reset = 1'b0;
    #10 reset = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [IW-1:0] ins;
      logic [AW-1:0] rw;
      ins = IW'($urandom);
      case ($urandom_range(0, 3))
        0:       rw = ins[9:5];
        1:       rw = ins[4:0];
        default: rw = AW'($urandom_range(0, 2**AW - 1));
      endcase
      drive(ins, rw, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      tick();
      model_edge();
      check("rand_a", bus.A, m_a);
      check("rand_b", bus.B, m_b);
      if ($urandom_range(0, 49) == 0) begin
        #200 reset = 1'b0;
        #10;
        model_reset();
        check("rand_reset_a", bus.A, m_a);
        check("rand_reset_b", bus.B, m_b);
        #10 reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
